// File: rtl/rng_pkg.sv
// ============================================================================
// Module   : rng_pkg
// Desc     : Shared FSM state type and framing constants for the RNG server.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rng_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      WAIT_CTS = 2'd2,
      SEND     = 2'd3
   } rng_state_t;

   // start + 8 data + stop
   localparam int C_FRAME_BITS = 10;

   localparam int C_DEF_TRNG_WIDTH     = 4;
   localparam int C_DEF_WORDS_PER_BYTE = 8 / C_DEF_TRNG_WIDTH;

   function automatic int words_per_byte(input int width);
      return 8 / width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Desc     : Two-flop synchronizer for board-level inputs (rx, cts, button).
//            Powers up high so an idle-high line never shows a false edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
   input  logic clk,
   input  logic ext,
   output logic int_sync
);

   logic [1:0] r_sync = 2'b11;

   always_ff @(posedge clk) begin
      r_sync <= {r_sync[0], ext};
   end

   assign int_sync = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/rng_uart_core.sv
// ============================================================================
// Module   : rng_uart_core
// Desc     : Receives a byte count N over UART, gathers N bytes from the TRNG
//            word port and streams them back on TX under RTS/CTS control.
// Config   : RNG_ECHO_EN - echo the command byte before the random bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rng_uart_core
   import rng_pkg::*;
#(
   parameter int TRNG_WIDTH   = 4,
   parameter int CLKS_PER_BIT = 104
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  rx,
   input  logic                  cts,
   output logic                  tx,
   output logic                  rts,
   output logic                  trng_req,
   input  logic [TRNG_WIDTH-1:0] trng_word,
   input  logic                  trng_valid
);

   localparam int              C_CW        = $clog2(CLKS_PER_BIT);
   localparam logic [C_CW-1:0] C_BIT_LAST  = C_CW'(CLKS_PER_BIT - 1);
   localparam logic [C_CW-1:0] C_HALF_LAST = C_CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]      C_STOP_IDX  = 4'(C_FRAME_BITS - 1);
   localparam logic [2:0]      C_WORD_LAST = 3'(words_per_byte(TRNG_WIDTH) - 1);
`ifdef RNG_ECHO_EN
   localparam bit              C_ECHO      = 1'b1;
`else
   localparam bit              C_ECHO      = 1'b0;
`endif

   logic            r_rx_prev, r_rx_busy, r_rx_valid;
   logic [C_CW-1:0] r_rx_cnt;
   logic [3:0]      r_rx_idx;
   logic [7:0]      r_rx_sh, r_rx_byte;

   rng_state_t      r_state, w_state_nxt;
   logic [7:0]      r_remaining, r_byte, w_byte_nxt;
   logic [2:0]      r_wcnt;
   logic [9:0]      r_tx_sh;
   logic [C_CW-1:0] r_tx_cnt;
   logic [3:0]      r_tx_idx;
   logic            r_rts, r_echo;
   logic            w_cmd_ok, w_take, w_word_last, w_tx_done;

   // Receiver: index 0 is the start bit, 1..8 data, 9 stop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rx_prev  <= 1'b1;
         r_rx_busy  <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_sh    <= '0;
         r_rx_byte  <= '0;
      end else begin
         r_rx_prev  <= rx;
         r_rx_valid <= 1'b0;
         if (!r_rx_busy) begin
            if (r_rx_prev && !rx) begin
               r_rx_busy <= 1'b1;
               r_rx_cnt  <= C_HALF_LAST;
               r_rx_idx  <= '0;
            end
         end else if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
         end else begin
            r_rx_cnt <= C_BIT_LAST;
            r_rx_idx <= r_rx_idx + 1'b1;
            if (r_rx_idx == 4'd0) begin
               if (rx) r_rx_busy <= 1'b0;
            end else if (r_rx_idx == C_STOP_IDX) begin
               r_rx_busy  <= 1'b0;
               r_rx_valid <= rx;
               r_rx_byte  <= r_rx_sh;
            end else begin
               r_rx_sh <= {rx, r_rx_sh[7:1]};
            end
         end
      end
   end

   assign w_cmd_ok    = r_rx_valid && (r_rx_byte != 8'd0);
   assign w_take      = (r_state == COLLECT) && trng_valid;
   assign w_word_last = w_take && (r_wcnt == C_WORD_LAST);
   assign w_tx_done   = (r_state == SEND) && (r_tx_cnt == '0) && (r_tx_idx == C_STOP_IDX);

   // New words enter at the top so the first word ends up in the low bits
   generate
      if (TRNG_WIDTH == 8) begin : g_word_full
         assign w_byte_nxt = trng_word;
      end else begin : g_word_shift
         assign w_byte_nxt = {trng_word, r_byte[7:TRNG_WIDTH]};
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_cmd_ok)    w_state_nxt = C_ECHO ? WAIT_CTS : COLLECT;
         COLLECT:  if (w_word_last) w_state_nxt = WAIT_CTS;
         WAIT_CTS: if (!cts)        w_state_nxt = SEND;
         SEND: begin
            if (w_tx_done) begin
               if (!r_echo && (r_remaining == 8'd1)) w_state_nxt = IDLE;
               else                                  w_state_nxt = COLLECT;
            end
         end
         default:                   w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_remaining <= '0;
         r_byte      <= '0;
         r_wcnt      <= '0;
         r_tx_sh     <= '1;
         r_tx_cnt    <= '0;
         r_tx_idx    <= '0;
         r_rts       <= 1'b1;
         r_echo      <= 1'b0;
      end else begin
         r_rts <= (w_state_nxt != IDLE);
         case (r_state)
            IDLE: begin
               if (w_cmd_ok) begin
                  r_remaining <= r_rx_byte;
                  r_byte      <= r_rx_byte;
                  r_echo      <= C_ECHO;
                  r_wcnt      <= '0;
               end
            end
            COLLECT: begin
               if (w_take) begin
                  r_byte <= w_byte_nxt;
                  r_wcnt <= w_word_last ? 3'd0 : r_wcnt + 1'b1;
               end
            end
            WAIT_CTS: begin
               if (!cts) begin
                  r_tx_sh  <= {1'b1, r_byte, 1'b0};
                  r_tx_cnt <= C_BIT_LAST;
                  r_tx_idx <= '0;
               end
            end
            SEND: begin
               if (r_tx_cnt != '0) begin
                  r_tx_cnt <= r_tx_cnt - 1'b1;
               end else begin
                  r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
                  r_tx_cnt <= C_BIT_LAST;
                  r_tx_idx <= r_tx_idx + 1'b1;
                  if (w_tx_done) begin
                     if (r_echo) r_echo      <= 1'b0;
                     else        r_remaining <= r_remaining - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign tx       = r_tx_sh[0];
   assign rts      = r_rts;
   assign trng_req = (r_state == COLLECT);

endmodule

`default_nettype wire

// File: tb/tb_rng_uart_core.sv
// ============================================================================
// Module   : tb_rng_uart_core
// Desc     : Scoreboard bench for rng_uart_core (CLKS_PER_BIT=4, TRNG_WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rng_uart_core;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       rx = 1'b1;
   logic       cts = 1'b0;
   logic       tx, rts, trng_req;
   logic [3:0] trng_word = 4'h0;
   logic       trng_valid = 1'b0;

   int         n_checks = 0;
   int         n_errors = 0;
   int         frames_seen = 0;
   bit         frame_active = 1'b0;
   int         trng_mode = 0;
   int         trng_consumed = 0;
   logic [7:0] exp_q[$];
   logic [3:0] trng_q[$];

   rng_uart_core #(
      .TRNG_WIDTH   (4),
      .CLKS_PER_BIT (4)
   ) u_dut (
      .clk        (clk),
      .resetn     (resetn),
      .rx         (rx),
      .cts        (cts),
      .tx         (tx),
      .rts        (rts),
      .trng_req   (trng_req),
      .trng_word  (trng_word),
      .trng_valid (trng_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // TRNG source: a word is consumed when req&valid are both high at a posedge
   initial begin : trng_model
      bit take_prev;
      int cyc;
      take_prev = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (take_prev) begin
            if (trng_q.size() > 0) void'(trng_q.pop_front());
            trng_consumed++;
         end
         cyc++;
         trng_valid = (trng_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         trng_word  = (trng_q.size() > 0) ? trng_q[0] : 4'hF;
         take_prev  = trng_req && trng_valid;
      end
   end

   // TX monitor: decode each frame at mid-bit and compare against the queue
   initial begin : tx_monitor
      logic [7:0] data;
      forever begin
         @(negedge clk);
         if (resetn && tx === 1'b0) begin
            frame_active = 1'b1;
            check("tx_start_cts", {31'd0, cts}, 32'd0);
            repeat (2) @(negedge clk);
            check("start_bit", {31'd0, tx}, 32'd0);
            for (int b = 0; b < 8; b++) begin
               repeat (4) @(negedge clk);
               data[b] = tx;
            end
            repeat (4) @(negedge clk);
            check("stop_bit", {31'd0, tx}, 32'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_frame", {24'd0, data}, 32'hFFFF_FFFF);
            end else begin
               check("tx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
            frames_seen++;
            frame_active = 1'b0;
         end
      end
   end

   task automatic uart_send(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (4) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic wait_frames(input string name, input int n, input int budget);
      int c;
      c = 0;
      while (frames_seen < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      check(name, frames_seen, n);
   endtask

   task automatic wait_words(input string name, input int n, input int budget);
      int c;
      c = 0;
      while (trng_consumed < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      check(name, trng_consumed, n);
   endtask

   task automatic observe_quiet(input string tag, input int cycles);
      int req_hi, tx_lo, rts_hi;
      req_hi = 0; tx_lo = 0; rts_hi = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (trng_req) req_hi++;
         if (!tx)      tx_lo++;
         if (rts)      rts_hi++;
      end
      check({tag, "_req"}, req_hi, 0);
      check({tag, "_tx"},  tx_lo,  0);
      check({tag, "_rts"}, rts_hi, 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int tx_lo, rts_lo, c;

      // Reset state and rts release
      repeat (3) @(negedge clk);
      check("rst_tx",   {31'd0, tx},       32'd1);
      check("rst_rts",  {31'd0, rts},      32'd1);
      check("rst_req",  {31'd0, trng_req}, 32'd0);
      resetn = 1'b1;
      #1 check("rts_before_clk", {31'd0, rts}, 32'd1);
      @(negedge clk);
      check("rts_after_clk", {31'd0, rts}, 32'd0);
      repeat (3) @(negedge clk);

      // Two-byte request, TRNG always valid
      trng_q = '{4'h1, 4'h2, 4'h3, 4'h4};
      exp_q.push_back(8'h21);
      exp_q.push_back(8'h43);
      uart_send(8'h02, 1'b1);
      wait_frames("a_frames", 2, 400);
      check("a_rts_busy", {31'd0, rts}, 32'd1);
      repeat (4) @(negedge clk);
      check("a_rts_done", {31'd0, rts}, 32'd0);
      check("a_words", trng_consumed, 4);
      repeat (5) @(negedge clk);

      // cts held high: byte is collected then parked
      cts = 1'b1;
      trng_q = '{4'hA, 4'h5};
      exp_q.push_back(8'h5A);
      uart_send(8'h01, 1'b1);
      wait_words("b_words", 6, 50);
      repeat (3) @(negedge clk);
      check("b_req_low", {31'd0, trng_req}, 32'd0);
      tx_lo = 0; rts_lo = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!tx)  tx_lo++;
         if (!rts) rts_lo++;
      end
      check("b_tx_hold",  tx_lo,  0);
      check("b_rts_hold", rts_lo, 0);
      check("b_trng_words", trng_consumed, 6);
      cts = 1'b0;
      wait_frames("b_frames", 3, 200);
      repeat (4) @(negedge clk);
      check("b_rts_done", {31'd0, rts}, 32'd0);

      // Zero-length command is ignored
      uart_send(8'h00, 1'b1);
      observe_quiet("c_zero", 60);

      // Framing error discards the command
      uart_send(8'h01, 1'b0);
      observe_quiet("d_frame_err", 60);
      check("d_words", trng_consumed, 6);

      // Sparse trng_valid; second command during SEND must be dropped
      trng_mode = 1;
      trng_q = '{4'h6, 4'h9, 4'hC, 4'h3};
      exp_q.push_back(8'h96);
      exp_q.push_back(8'h3C);
      uart_send(8'h02, 1'b1);
      c = 0;
      while (!frame_active && c < 300) begin
         @(negedge clk);
         c++;
      end
      check("e_frame_start", {31'd0, frame_active}, 32'd1);
      check("e_words_first", trng_consumed, 8);
      uart_send(8'h01, 1'b1);
      wait_frames("e_frames", 5, 400);
      repeat (4) @(negedge clk);
      check("e_rts_done", {31'd0, rts}, 32'd0);
      check("e_words", trng_consumed, 10);
      repeat (150) @(negedge clk);
      check("e_no_extra", frames_seen, 5);
      check("e_queue_empty", exp_q.size(), 0);
      check("e_req_idle", {31'd0, trng_req}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
